// File: rtl/wbu_cwassemble_pkg.sv
// Shared types and helpers for the receive-side codeword assembler.
// Holds the 6-bit character map, header length decode and state encoding.
package wbu_cwassemble_pkg;

  localparam int unsigned CwW  = 36;
  localparam int unsigned SixW = 6;

  localparam logic [2:0] LEN1 = 3'd1;
  localparam logic [2:0] LEN2 = 3'd2;
  localparam logic [2:0] LEN3 = 3'd3;
  localparam logic [2:0] LEN6 = 3'd6;

  // Header bits [5:3] select the word length.
  localparam logic [5:0] HdrLenMask = 6'b111000;

  typedef enum logic {StIdle, StCollect} state_e;

  typedef struct packed {
    logic            valid;
    logic            sep;
    logic [SixW-1:0] six;
  } six_t;

  function automatic logic [2:0] hdr_len(input logic [SixW-1:0] hdr);
    logic [5:0] code;
    code = hdr & HdrLenMask;
    casez (code[5:3])
      3'b0??:  hdr_len = LEN6;
      3'b100:  hdr_len = LEN2;
      3'b101:  hdr_len = LEN3;
      default: hdr_len = LEN1;
    endcase
  endfunction

  // Printable set maps to 0..63; any other byte is a separator.
  function automatic six_t char_map(input logic [7:0] b);
    six_t       r;
    logic [7:0] d;
    r = '0;
    d = 8'd0;
    if (b >= 8'h30 && b <= 8'h39) begin
      d = b - 8'h30;
      r.valid = 1'b1;
    end else if (b >= 8'h41 && b <= 8'h5a) begin
      d = b - 8'd55;
      r.valid = 1'b1;
    end else if (b >= 8'h61 && b <= 8'h7a) begin
      d = b - 8'd61;
      r.valid = 1'b1;
    end else if (b == 8'h40) begin
      d = 8'd62;
      r.valid = 1'b1;
    end else if (b == 8'h25) begin
      d = 8'd63;
      r.valid = 1'b1;
    end
    r.six = d[SixW-1:0];
    r.sep = ~r.valid;
    return r;
  endfunction

endpackage

// File: rtl/wbu_cwassemble_if.sv
// Byte-in / codeword-out handshake bundle for the codeword assembler.
interface wbu_cwassemble_if import wbu_cwassemble_pkg::*;;
  logic           i_stb;
  logic [7:0]     i_byte;
  logic           i_busy;
  logic           o_stb;
  logic [CwW-1:0] o_codword;
  logic           o_active;
  logic           o_err;

  modport slave (
    input  i_stb, i_byte, i_busy,
    output o_stb, o_codword, o_active, o_err
  );

  modport master (
    output i_stb, i_byte, i_busy,
    input  o_stb, o_codword, o_active, o_err
  );
endinterface

// File: rtl/wbu_chartosix.sv
// Registered byte to {valid, sep, 6-bit} character map; idle cycles give all-zero.
module wbu_chartosix import wbu_cwassemble_pkg::*; (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_stb,
  input  logic [7:0] i_byte,
  output six_t       o_chr
);

  six_t chr_d, chr_q;

  always_comb begin
    chr_d = '0;
    if (i_stb) chr_d = char_map(i_byte);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) chr_q <= '0;
    else          chr_q <= chr_d;
  end

  assign o_chr = chr_q;

endmodule

// File: rtl/wbu_cwassemble.sv
// Frames mapped characters into left-justified 36-bit codewords and hands them
// downstream with a valid/busy handshake; flags framing, timeout and overflow.
module wbu_cwassemble import wbu_cwassemble_pkg::*; #(
  parameter int unsigned      LGTO    = 20,
  parameter logic [LGTO-1:0]  TIMEOUT = 20'd1000000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  wbu_cwassemble_if.slave  bus
);

  localparam logic [LGTO-1:0] ToLast = TIMEOUT - 1'b1;

  six_t chr;

  wbu_chartosix u_map (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_stb   (bus.i_stb),
    .i_byte  (bus.i_byte),
    .o_chr   (chr)
  );

  state_e          state_d, state_q;
  logic [CwW-1:0]  shreg_d, shreg_q;
  logic [2:0]      cnt_d, cnt_q;
  logic [2:0]      len_d, len_q;
  logic [LGTO-1:0] to_d, to_q;
  logic            ostb_d, ostb_q;
  logic [CwW-1:0]  cw_d, cw_q;
  logic            err_d, err_q;
  logic            new_word, frame_err, to_err, ovf_err, xfer;
  int unsigned     sh;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    to_d      = to_q;
    new_word  = 1'b0;
    frame_err = 1'b0;
    to_err    = 1'b0;
    sh        = 0;
    unique case (state_q)
      StIdle: begin
        to_d = '0;
        if (chr.valid) begin
          shreg_d = {chr.six, {(CwW-SixW){1'b0}}};
          len_d   = hdr_len(chr.six);
          cnt_d   = 3'd1;
          if (hdr_len(chr.six) == LEN1) new_word = 1'b1;
          else                          state_d  = StCollect;
        end
      end
      StCollect: begin
        if (chr.valid) begin
          to_d    = '0;
          // Char k lands at bits [35-6k -: 6]; lower bits are already zero.
          sh      = 6 * (5 - int'(cnt_q));
          shreg_d = shreg_q | ({{(CwW-SixW){1'b0}}, chr.six} << sh);
          cnt_d   = cnt_q + 3'd1;
          if (cnt_d == len_q) begin
            new_word = 1'b1;
            state_d  = StIdle;
          end
        end else if (chr.sep) begin
          frame_err = 1'b1;
          to_d      = '0;
          state_d   = StIdle;
        end else if (to_q == ToLast) begin
          to_err  = 1'b1;
          to_d    = '0;
          state_d = StIdle;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output holding register: a word completing while the held one is stalled is dropped.
  always_comb begin
    xfer    = ostb_q && !bus.i_busy;
    ostb_d  = ostb_q;
    cw_d    = cw_q;
    ovf_err = 1'b0;
    if (new_word) begin
      if (!ostb_q || xfer) begin
        ostb_d = 1'b1;
        cw_d   = shreg_d;
      end else begin
        ovf_err = 1'b1;
      end
    end else if (xfer) begin
      ostb_d = 1'b0;
    end
    err_d = frame_err | to_err | ovf_err;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      to_q    <= '0;
      ostb_q  <= 1'b0;
      cw_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      to_q    <= to_d;
      ostb_q  <= ostb_d;
      cw_q    <= cw_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_stb     = ostb_q;
  assign bus.o_codword = cw_q;
  assign bus.o_err     = err_q;
  assign bus.o_active  = (state_q == StCollect);

endmodule

// File: tb/tb_wbu_cwassemble.sv
// Directed bench for wbu_cwassemble: word framing, errors, timeout and backpressure.
module tb_wbu_cwassemble;

  localparam logic [19:0] TO = 20'd50;

  logic i_clk;
  logic i_rst_n;
  int   errors = 0;
  int   total  = 0;
  int   nerr   = 0;
  logic [35:0] xfers[$];

  wbu_cwassemble_if bus ();

  wbu_cwassemble #(
    .LGTO    (20),
    .TIMEOUT (TO)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Record transfers and error pulses mid-cycle, away from the active edge.
  always @(negedge i_clk) begin
    if (bus.o_stb && !bus.i_busy) xfers.push_back(bus.o_codword);
    if (bus.o_err) nerr++;
  end

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    total++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c);
    bus.i_stb  = 1'b1;
    bus.i_byte = c;
    @(posedge i_clk);
    #1;
    bus.i_stb  = 1'b0;
    bus.i_byte = 8'h00;
  endtask

  task automatic expect_words(input string tag, input int n, input logic [35:0] w0,
                              input logic [35:0] w1, input int exp_err);
    logic [35:0] got;
    check({tag, "_count"}, 36'(xfers.size()), 36'(n));
    for (int i = 0; i < n; i++) begin
      got = (i < xfers.size()) ? xfers[i] : 36'hx;
      check($sformatf("%s_word%0d", tag, i), got, (i == 0) ? w0 : w1);
    end
    check({tag, "_errs"}, 36'(nerr), 36'(exp_err));
    xfers.delete();
    nerr = 0;
  endtask

  initial begin
    i_rst_n    = 1'b0;
    bus.i_stb  = 1'b0;
    bus.i_byte = 8'h00;
    bus.i_busy = 1'b0;
    idle(2);
    check("rst_stb", 36'(bus.o_stb), 36'd0);
    check("rst_cw", bus.o_codword, 36'd0);
    check("rst_active", 36'(bus.o_active), 36'd0);
    check("rst_err", 36'(bus.o_err), 36'd0);
    send("m");
    idle(2);
    check("rst_ignore_stb", 36'(bus.o_stb), 36'd0);
    i_rst_n = 1'b1;
    idle(2);
    xfers.delete();
    nerr = 0;

    // 1-char word with latency check
    send("m");
    check("m_lat1", 36'(bus.o_stb), 36'd0);
    idle(1);
    check("m_lat2", 36'(bus.o_stb), 36'd1);
    check("m_cw", bus.o_codword, 36'hC00000000);
    idle(3);
    expect_words("m", 1, 36'hC00000000, 36'h0, 0);

    send("W"); send("5");
    idle(4);
    expect_words("W5", 1, 36'h805000000, 36'h0, 0);

    send("e"); send("A"); send("B");
    idle(4);
    expect_words("eAB", 1, 36'hA0A2C0000, 36'h0, 0);

    send("0"); send("1");
    check("six_act1", 36'(bus.o_active), 36'd1);
    send("2"); send("3"); send("4"); send("5");
    check("six_act5", 36'(bus.o_active), 36'd1);
    idle(1);
    check("six_act_done", 36'(bus.o_active), 36'd0);
    idle(3);
    expect_words("six", 1, 36'h001083105, 36'h0, 0);

    // Framing error, then recovery
    send("0"); send("1"); send(8'h0A);
    idle(4);
    check("frm_active", 36'(bus.o_active), 36'd0);
    expect_words("frm", 0, 36'h0, 36'h0, 1);
    send("m");
    idle(4);
    expect_words("frm_m", 1, 36'hC00000000, 36'h0, 0);

    // Timeout
    send("0"); send("1");
    idle(45);
    check("to_early_active", 36'(bus.o_active), 36'd1);
    check("to_early_err", 36'(nerr), 36'd0);
    idle(10);
    check("to_active", 36'(bus.o_active), 36'd0);
    expect_words("to", 0, 36'h0, 36'h0, 1);
    send("2");
    idle(1);
    check("to_hdr_active", 36'(bus.o_active), 36'd1);
    send("0"); send("0"); send("0"); send("0"); send("0");
    idle(4);
    expect_words("to_next", 1, 36'h080000000, 36'h0, 0);

    // Backpressure: second word dropped with one error pulse
    bus.i_busy = 1'b1;
    send("m");
    idle(2);
    check("bp_stb", 36'(bus.o_stb), 36'd1);
    send("n");
    idle(3);
    check("bp_hold_stb", 36'(bus.o_stb), 36'd1);
    check("bp_hold_cw", bus.o_codword, 36'hC00000000);
    bus.i_busy = 1'b0;
    idle(3);
    check("bp_stb_clr", 36'(bus.o_stb), 36'd0);
    expect_words("bp", 1, 36'hC00000000, 36'h0, 1);

    // Busy drops on the cycle the second word completes
    bus.i_busy = 1'b1;
    send("m");
    idle(2);
    send("n");
    bus.i_busy = 1'b0;
    idle(4);
    expect_words("bp_same", 2, 36'hC00000000, 36'hC40000000, 0);

    // Reset mid-word
    send("0"); send("1");
    i_rst_n = 1'b0;
    idle(1);
    check("mrst_active", 36'(bus.o_active), 36'd0);
    check("mrst_stb", 36'(bus.o_stb), 36'd0);
    i_rst_n = 1'b1;
    idle(1);
    send("m");
    idle(4);
    expect_words("mrst", 1, 36'hC00000000, 36'h0, 0);

    $display("Result: errors=%0d of %0d checks", errors, total);
    $finish;
  end

endmodule
